// File: rtl/spi_pkg.sv
// Shared SPI master definitions.
//   rx_state_e : receive FSM states
//   *_DEFAULT  : default datapath / length-field widths
//   len_decode : maps a char_len field to a frame length 1..2**len_w
package spi_pkg;

  localparam int unsigned DATA_W_DEFAULT = 128;
  localparam int unsigned LEN_W_DEFAULT  = 6;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } rx_state_e;

  // A zero length field stands for the largest frame, 2**len_w bits.
  function automatic int unsigned len_decode(input int unsigned char_len,
                                             input int unsigned len_w);
    return (char_len == 0) ? (32'd1 << len_w) : char_len;
  endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// Receive bit counter.
//   clk, reset : system clock, synchronous active-high reset
//   load       : capture frame length n_in and clear the count
//   step       : one bit sampled this edge
//   n_in       : decoded frame length (1..2**(CNT_W-1))
//   count      : bits sampled so far in the current frame
//   last       : the next sampled bit completes the frame
module rx_bit_counter #(
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [CNT_W-1:0] n_in,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] n_q, n_d;

  always_comb begin
    count_d = count_q;
    n_d     = n_q;
    if (load) begin
      count_d = '0;
      n_d     = n_in;
    end else if (step) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      n_q     <= '0;
    end else begin
      count_q <= count_d;
      n_q     <= n_d;
    end
  end

  assign count = count_q;
  assign last  = ((count_q + CNT_W'(1)) == n_q);

endmodule

// File: rtl/rx_shift_register.sv
// SPI master receive datapath: deserialises miso into a right-aligned word.
//   clk, reset  : system clock, synchronous active-high reset
//   char_len    : frame length in bits (0 encodes 2**LEN_W)
//   miso        : serial data from slave
//   go_busy     : level request to start / continue a frame
//   lsb         : 0 = MSB-first, 1 = LSB-first
//   outrxd      : last completed word, upper bits zero
//   rx_complete : one-cycle pulse when outrxd is updated
//   clk_out     : gated serial clock, running only while a frame is active
module rx_shift_register
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned LEN_W  = LEN_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LEN_W-1:0]  char_len,
  input  logic              miso,
  input  logic              go_busy,
  input  logic              lsb,
  output logic [DATA_W-1:0] outrxd,
  output logic              rx_complete,
  output logic              clk_out
);

  localparam int unsigned CNT_W = LEN_W + 1;

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [DATA_W-1:0] outrxd_q, outrxd_d;
  logic              rx_complete_q, rx_complete_d;
  logic              lsb_q, lsb_d;
  logic              en_q, en_d;

  logic              cnt_load, cnt_step, cnt_last;
  logic [CNT_W-1:0]  cnt_value;
  logic [CNT_W-1:0]  n_decoded;

  assign n_decoded = CNT_W'(len_decode(32'(char_len), LEN_W));

  rx_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .step  (cnt_step),
    .n_in  (n_decoded),
    .count (cnt_value),
    .last  (cnt_last)
  );

  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    outrxd_d      = outrxd_q;
    rx_complete_d = 1'b0;
    lsb_d         = lsb_q;
    cnt_load      = 1'b0;
    cnt_step      = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_busy) begin
          lsb_d    = lsb;
          sr_d     = '0;
          cnt_load = 1'b1;
          state_d  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (go_busy) begin
          cnt_step = 1'b1;
          if (lsb_q) sr_d[cnt_value] = miso;
          else       sr_d = {sr_q[DATA_W-2:0], miso};
          // Register was cleared at frame start, so bits >= N are already zero.
          if (cnt_last) begin
            outrxd_d      = sr_d;
            rx_complete_d = 1'b1;
            state_d       = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      sr_q          <= '0;
      outrxd_q      <= '0;
      rx_complete_q <= 1'b0;
      lsb_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      outrxd_q      <= outrxd_d;
      rx_complete_q <= rx_complete_d;
      lsb_q         <= lsb_d;
    end
  end

  // Enable changes only while clk is low, so the AND gate cannot glitch.
  always_comb en_d = !reset && (state_q == ACTIVE);

  always_ff @(negedge clk) en_q <= en_d;

  assign clk_out     = clk & en_q;
  assign outrxd      = outrxd_q;
  assign rx_complete = rx_complete_q;

endmodule

// File: tb/tb_rx_shift_register.sv
module tb_rx_shift_register;

  logic         clk = 1'b0;
  logic         reset;
  logic [5:0]   char_len;
  logic         miso;
  logic         go_busy;
  logic         lsb;
  logic [127:0] outrxd;
  logic         rx_complete;
  logic         clk_out;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned edges  = 0;
  int unsigned pulses = 0;
  int unsigned exp_pulses = 0;
  logic [63:0] exp_out = '0;

  rx_shift_register #(
    .DATA_W (128),
    .LEN_W  (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .char_len    (char_len),
    .miso        (miso),
    .go_busy     (go_busy),
    .lsb         (lsb),
    .outrxd      (outrxd),
    .rx_complete (rx_complete),
    .clk_out     (clk_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk_out) edges++;
  always @(negedge clk) if (rx_complete === 1'b1) pulses++;

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Idle clk_out must stay low; sampled just after a rising clk edge.
  task automatic idle_check();
    @(posedge clk); #1;
    chk("idle_clk_out", 128'(clk_out), 128'(0));
    @(negedge clk); #1;
  endtask

  // One frame of n bits carrying value v. abort_at >= 0 drops go_busy at that bit.
  // hold keeps go_busy high after completion so the next frame follows immediately.
  task automatic run_frame(input int unsigned n, input logic [63:0] v, input logic l,
                           input int abort_at, input logic hold);
    logic [63:0] val;
    int unsigned e0, e1;
    logic aborted;
    val = (n == 64) ? v : (v & ((64'd1 << n) - 64'd1));
    e0 = edges;
    aborted = 1'b0;
    go_busy  = 1'b1;
    char_len = 6'(n);
    lsb      = l;
    miso     = 1'($urandom);
    @(negedge clk); #1;
    chk("start_rxc_low", 128'(rx_complete), 128'(0));
    for (int i = 0; i < int'(n); i++) begin
      if (abort_at >= 0 && i == abort_at) begin
        go_busy = 1'b0;
        miso    = 1'($urandom);
        @(negedge clk); #1;
        aborted = 1'b1;
        break;
      end
      miso     = l ? val[i] : val[int'(n) - 1 - i];
      char_len = 6'($urandom);
      lsb      = 1'($urandom);
      @(negedge clk); #1;
    end
    if (aborted) begin
      chk("abort_no_rxc", 128'(rx_complete), 128'(0));
      chk("abort_hold", outrxd, {64'b0, exp_out});
      e1 = edges;
      repeat (3) @(negedge clk);
      #1;
      chk("abort_clk_stop", 128'(edges), 128'(e1));
      chk("abort_hold2", outrxd, {64'b0, exp_out});
      idle_check();
    end else begin
      exp_out = val;
      exp_pulses++;
      chk("done_rxc", 128'(rx_complete), 128'(1));
      chk("done_data", outrxd, {64'b0, val});
      chk("clk_edges", 128'(edges - e0), 128'(n));
      if (!hold) begin
        go_busy = 1'b0;
        @(negedge clk); #1;
        chk("rxc_one_cycle", 128'(rx_complete), 128'(0));
        chk("data_hold", outrxd, {64'b0, val});
        idle_check();
      end
    end
  endtask

  initial begin
    reset = 1'b1; go_busy = 1'b0; char_len = '0; miso = 1'b0; lsb = 1'b0;

    // Reset held for two cycles
    @(posedge clk);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_outrxd", outrxd, 128'(0));
      chk("rst_rxc", 128'(rx_complete), 128'(0));
      chk("rst_clk_out", 128'(clk_out), 128'(0));
    end
    @(negedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;

    run_frame(24, 64'h002AC7, 1'b0, -1, 1'b0);
    run_frame(12, 64'hCAA, 1'b1, -1, 1'b0);
    run_frame(64, 64'hDEADBEEF_01234567, 1'b0, -1, 1'b0);
    run_frame(24, 64'h00F0F0F0, 1'b0, 10, 1'b0);
    run_frame(8, 64'hA5, 1'b0, -1, 1'b1);
    run_frame(8, 64'h3C, 1'b0, -1, 1'b0);
    run_frame(1, 64'h1, 1'b1, -1, 1'b0);
    run_frame(64, 64'h8000_0000_0000_0001, 1'b1, -1, 1'b0);

    // Reset in the middle of a frame clears the held word
    go_busy = 1'b1; char_len = 6'd20; lsb = 1'b0;
    repeat (8) begin
      @(negedge clk); #1;
      miso = 1'($urandom);
    end
    reset = 1'b1;
    @(negedge clk); #1;
    chk("midrst_outrxd", outrxd, 128'(0));
    chk("midrst_rxc", 128'(rx_complete), 128'(0));
    exp_out = '0;
    reset = 1'b0; go_busy = 1'b0;
    @(negedge clk); #1;
    idle_check();

    for (int k = 0; k < 30; k++) begin
      int unsigned n;
      int ab;
      logic h;
      n  = $urandom_range(64, 1);
      ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
      h  = (k != 29) && (ab < 0) && 1'($urandom);
      run_frame(n, {$urandom, $urandom}, 1'($urandom), ab, h);
    end

    chk("pulse_total", 128'(pulses), 128'(exp_pulses));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
